// File: rtl/dma_pkg.sv
// Shared types and constants for the word-granular DMA copy engine.
package dma_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } dma_state_e;

    // Byte address of word idx past base, wrapping modulo 2^32.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] idx);
        return base + ADDR_W'(idx * ADDR_W'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/dma_copy_engine.sv
// Memory-to-memory word copy: one READ cycle then one WRITE cycle per word.
// All outputs are registered from the next-state decode so they track the state.
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [LEN_WIDTH-1:0] len_words,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 MemWrite,
    output logic [ADDR_W-1:0]    Address,
    output logic [DATA_W-1:0]    WriteData,
    input  logic [DATA_W-1:0]    ReadData
);

    dma_state_e             state_q, state_d;
    logic [ADDR_W-1:0]      src_q, src_d;
    logic [ADDR_W-1:0]      dst_q, dst_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   idx_q, idx_d;
    logic [LEN_WIDTH-1:0]   idx_inc;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   busy_d, done_d, error_d, we_d;
    logic [ADDR_W-1:0]      addr_d;
    logic [DATA_W-1:0]      wdata_d;
    logic                   misaligned;

    assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
    assign idx_inc    = idx_q + LEN_WIDTH'(1);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            MemWrite  <= 1'b0;
            Address   <= '0;
            WriteData <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
            MemWrite  <= we_d;
            Address   <= addr_d;
            WriteData <= wdata_d;
        end
    end

    // Next-state logic, then output decode of the state being entered.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        state_d = ERR;
                    end else if (len_words == '0) begin
                        state_d = DONE;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        len_d   = len_words;
                        idx_d   = '0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                hold_d  = ReadData;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? DONE : READ;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        unique case (state_d)
            READ:  addr_d = word_addr(src_d, ADDR_W'(idx_d));
            WRITE: begin
                addr_d  = word_addr(dst_d, ADDR_W'(idx_d));
                wdata_d = hold_d;
                we_d    = 1'b1;
            end
            DONE:    done_d  = 1'b1;
            ERR:     error_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Scoreboard bench for dma_copy_engine: stimulus pushes expected memory transactions,
// a negedge monitor pops and compares every access, done and error cycle.
module tb_dma_copy_engine;

    localparam int unsigned LW = 11;
    localparam int KRD = 0, KWR = 1, KDN = 2, KER = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   src_addr = '0, dst_addr = '0;
    logic [LW-1:0] len_words = '0;
    logic          busy, done, error, MemWrite;
    logic [31:0]   Address, WriteData, ReadData;

    logic [31:0]   mem [1024];
    logic          mem_init = 1'b1;
    logic          pre_we = 1'b0;
    logic [9:0]    pre_idx = '0;
    logic [31:0]   pre_data = '0;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t sb [$];

    int n_chk = 0;
    int n_fail = 0;

    dma_copy_engine #(.LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len_words(len_words), .busy(busy), .done(done),
        .error(error), .MemWrite(MemWrite), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    // Data memory, aliased on Address[11:2]; words default to 0xC0000000|index.
    assign ReadData = mem[Address[11:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 32'hC000_0000 | 32'(k);
        end else if (MemWrite) begin
            mem[Address[11:2]] <= WriteData;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    task automatic check(input bit ok, input string name,
                         input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.kind = kind;
        t.addr = addr;
        t.data = data;
        sb.push_back(t);
    endtask

    // Monitor: every busy cycle is one transaction; idle cycles must be all-zero.
    always @(negedge clk) begin
        if (rst_n && !mem_init) begin
            if (done && error)
                check(1'b0, "done_and_error", 96'(3), 96'(0));
            if (!busy) begin
                check(!MemWrite && !done && !error && Address == 0 && WriteData == 0,
                      "idle_outputs", {32'({MemWrite, done, error}), Address, WriteData}, 96'(0));
            end else begin
                int   kind;
                txn_t e;
                kind = MemWrite ? KWR : done ? KDN : error ? KER : KRD;
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_txn", {32'(kind), Address, WriteData}, 96'(0));
                end else begin
                    e = sb.pop_front();
                    check(kind == e.kind && Address == e.addr &&
                          (kind == KRD || WriteData == e.data), "txn",
                          {32'(kind), Address, WriteData}, {32'(e.kind), e.addr, e.data});
                end
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = 10'(idx); pre_data = v;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] l);
        @(negedge clk);
        src_addr = s; dst_addr = d; len_words = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one request; latency is negedges from the start edge to done/error.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] l,
                       input int exp_cyc, input bit glitch);
        int n;
        kick(s, d, l);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (glitch && n == 3) begin
                start = 1'b1; src_addr = 32'h0; dst_addr = 32'h380; len_words = 7;
            end
            if (glitch && n == 4) start = 1'b0;
        end while (!(done || error) && n < 200);
        check(n == exp_cyc, "latency", 96'(n), 96'(exp_cyc));
        @(negedge clk); #1;
        check(!busy && !done && !error, "pulse_one_cycle",
              96'({busy, done, error}), 96'(0));
        check(sb.size() == 0, "sb_drained", 96'(sb.size()), 96'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check(!busy && !done && !error && !MemWrite && Address == 0 && WriteData == 0,
              "reset_state", {29'(0), busy, done, error, Address, WriteData}, 96'(0));
        @(negedge clk);
        mem_init = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 4-word copy.
        for (int k = 0; k < 4; k++) preload(4 + k, 32'hA0 + 32'(k));
        for (int k = 0; k < 4; k++) begin
            push(KRD, 32'h10 + 32'(4 * k), 32'h0);
            push(KWR, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
        end
        push(KDN, 32'h0, 32'h0);
        run(32'h10, 32'h100, 4, 9, 1'b0);
        for (int k = 0; k < 4; k++)
            check(mem[64 + k] == 32'hA0 + 32'(k), "copy4_dst", 96'(mem[64 + k]), 96'(32'hA0 + k));

        // Zero length: done next cycle, no access.
        push(KDN, 32'h0, 32'h0);
        run(32'h10, 32'h100, 0, 1, 1'b0);

        // Misaligned source: error only.
        push(KER, 32'h0, 32'h0);
        run(32'h12, 32'h100, 4, 1, 1'b0);

        // Misaligned destination: error only.
        push(KER, 32'h0, 32'h0);
        run(32'h10, 32'h101, 2, 1, 1'b0);

        // Reset during third WRITE of a 5-word copy.
        for (int k = 0; k < 5; k++) preload(16 + k, 32'hB0 + 32'(k));
        for (int k = 0; k < 3; k++) begin
            push(KRD, 32'h40 + 32'(4 * k), 32'h0);
            push(KWR, 32'h200 + 32'(4 * k), 32'hB0 + 32'(k));
        end
        kick(32'h40, 32'h200, 5);
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check(!MemWrite && !busy && !done && Address == 0 && WriteData == 0, "reset_midcopy",
              {29'(0), MemWrite, busy, done, Address, WriteData}, 96'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check(mem[128] == 32'hB0, "reset_dst0", 96'(mem[128]), 96'(32'hB0));
        check(mem[129] == 32'hB1, "reset_dst1", 96'(mem[129]), 96'(32'hB1));
        check(mem[130] == 32'hC000_0082, "reset_dst2", 96'(mem[130]), 96'(32'hC000_0082));
        check(mem[131] == 32'hC000_0083, "reset_dst3", 96'(mem[131]), 96'(32'hC000_0083));
        check(sb.size() == 0, "reset_sb_drained", 96'(sb.size()), 96'(0));

        // Start re-pulsed mid-copy with other parameters is ignored.
        for (int k = 0; k < 3; k++) preload(8 + k, 32'hC0 + 32'(k));
        for (int k = 0; k < 3; k++) begin
            push(KRD, 32'h20 + 32'(4 * k), 32'h0);
            push(KWR, 32'h300 + 32'(4 * k), 32'hC0 + 32'(k));
        end
        push(KDN, 32'h0, 32'h0);
        run(32'h20, 32'h300, 3, 7, 1'b1);
        check(mem[224] == 32'hC000_00E0, "glitch_untouched", 96'(mem[224]), 96'(32'hC000_00E0));

        // Source address wraps through zero.
        preload(1022, 32'hD0);
        preload(1023, 32'hD1);
        preload(0, 32'hD2);
        push(KRD, 32'hFFFF_FFF8, 32'h0);
        push(KWR, 32'h500, 32'hD0);
        push(KRD, 32'hFFFF_FFFC, 32'h0);
        push(KWR, 32'h504, 32'hD1);
        push(KRD, 32'h0000_0000, 32'h0);
        push(KWR, 32'h508, 32'hD2);
        push(KDN, 32'h0, 32'h0);
        run(32'hFFFF_FFF8, 32'h500, 3, 7, 1'b0);
        check(mem[322] == 32'hD2, "wrap_dst2", 96'(mem[322]), 96'(32'hD2));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 11, giving the width of the word-count input (max 1024 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a copy request, sampled only in IDLE.
REQ-005 SHALL have port src_addr, input, 32, the source byte address, sampled with start.
REQ-006 SHALL have port dst_addr, input, 32, the destination byte address, sampled with start.
REQ-007 SHALL have port len_words, input, LEN_WIDTH, the number of 32-bit words to copy, sampled with start.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse on successful completion.
REQ-010 SHALL have port error, output, 1, a one-cycle pulse on a rejected request.
REQ-011 SHALL have port MemWrite, output, 1, the write strobe to data memory.
REQ-012 SHALL have port Address, output, 32, the byte address to data memory (word-aligned).
REQ-013 SHALL have port WriteData, output, 32, the write data to data memory.
REQ-014 SHALL have port ReadData, input, 32, the combinational read data from data memory, valid in the same cycle as Address.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, DONE, ERR.
REQ-016 SHALL, in IDLE with start=1 and src_addr[1:0] or dst_addr[1:0] nonzero, go to ERR; ERR lasts one cycle, asserts error, then returns to IDLE with no memory access.
REQ-017 SHALL, in IDLE with start=1, aligned addresses and len_words=0, go to DONE with no memory access.
REQ-018 SHALL, in IDLE with start=1, aligned addresses and len_words>0, latch src, dst and len, clear the word index i, and go to READ.
REQ-019 SHALL, in READ, drive Address=src+4*i and MemWrite=0, capture ReadData into a 32-bit holding register at the edge, and go to WRITE.
REQ-020 SHALL, in WRITE, drive Address=dst+4*i, WriteData=holding register and MemWrite=1; at the edge it increments i, then goes to DONE if i+1=len, else to READ.
REQ-021 SHALL hold DONE for exactly one cycle with done=1, then return to IDLE.
REQ-022 SHALL take 2*N cycles from the start edge to DONE for N>0, plus 1 DONE cycle.
REQ-023 SHALL compute addresses in 32-bit modulo arithmetic; 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-024 SHALL copy in ascending order only; overlapping regions with dst>src produce propagated data, which is defined behaviour.
REQ-025 SHALL ignore start in every state other than IDLE, with no effect on latched parameters.
REQ-026 SHALL drive MemWrite=0 in every state except WRITE; Address and WriteData are 0 in IDLE, DONE and ERR.
REQ-027 SHALL never assert done and error in the same cycle.

Reset
REQ-028 SHALL, on rst_n=0 at any time (including mid-copy), immediately force IDLE, MemWrite=0, busy=0, done=0, error=0, Address=0 and WriteData=0, and clear the holding register, index and latched parameters.
REQ-029 SHALL leave any partially completed copy partial after reset; words already written remain written, with no rollback.

Structure
REQ-030 SHALL place the state enum typedef and the constant WORD_BYTES=4 in shared package dma_pkg.
REQ-031 SHALL be a single module with no sub-module; the index counter and address adders are inline.

Verification
REQ-032 SHALL cover this scenario: preload mem[0x10..0x1C] with 0xA0..0xA3; start with src=0x10, dst=0x100, len=4 -> 8 busy cycles, then done for 1 cycle; mem[0x100..0x10C]=0xA0..0xA3.
REQ-033 SHALL cover this scenario: start with len=0 -> done on the cycle after start, MemWrite never asserted.
REQ-034 SHALL cover this scenario: start with src=0x12 -> error pulse for 1 cycle, done=0, MemWrite never asserted.
REQ-035 SHALL cover this scenario: drop rst_n during the 3rd WRITE of a len=5 copy -> MemWrite=0 immediately; only 2 destination words are changed; busy=0.
REQ-036 SHALL cover this scenario: start pulsed again mid-copy with different parameters -> ignored; the original copy completes unchanged.
REQ-037 SHALL cover this scenario: src=0xFFFFFFF8, len=3 -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
